ha_array_reducer: RTL
=====================

# ha_array_reducer

Multi-cycle final-adder stage that consumes the four half-adder array vector pairs (bottom/top) produced by the unsigned 8x8 HA-array partial-product stage and reduces them to the 16-bit product. It sits directly after that stage in the approximate-multiplier datapath. Inputs are captured with a valid/ready handshake. One array is accumulated per cycle, and the result is held under output backpressure.

## Interface
- `N_ARR`, 4: number of HA arrays consumed; array k carries weight 2^(2k).
- `T_W`, 9: width of each top vector.
- `B_W`, 7: width of each bottom vector.
- `P_W`, 16: product width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input vector set valid.
- `in_ready`  out  1  block can accept an input set.
- `ha_array_k_t` (k=0..3)  in  9 each  top vectors; bit i has weight 2^(i+2k).
- `ha_array_k_b` (k=0..3)  in  7 each  bottom (carry) vectors; bit i has weight 2^(i+2+2k).
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  downstream accepts product.
- `product`  out  16  reduced sum, low 16 bits.
- `overflow`  out  1  the 17-bit sum had bit 16 set; qualified by `out_valid`.

## Operation
- Per-array value: v_k = t_k + (b_k << 2), 10 bits, range 0..1019.
- Total: S = sum of v_k << 2k. The accumulator is 17 bits wide, because max S = 1019 * 85 = 86615. `product` = S[15:0]. `overflow` = S[16].
- FSM states:
  - IDLE: `in_ready`=1. On in_valid&in_ready, capture all 8 vectors, clear acc, set idx=0, go to ACC.
  - ACC: `in_ready`=0. Each cycle acc += v_idx << 2*idx and idx++. After the idx=3 add, go to DONE.
  - DONE: `out_valid`=1 and outputs are stable. If out_ready=1: `in_ready`=1. A simultaneous in_valid captures the new set and goes to ACC (back-to-back). Otherwise the next state is IDLE.
- Input vectors are sampled only on the capture edge. Changes to the inputs afterwards do not affect the in-flight result.
- The block does no approximation correction: it sums exactly what it receives.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, overflow=0, acc=0, idx=0, capture registers=0.
- Latency: capture at edge E0, accumulate at E1..E4, out_valid high after E4. That is 4 cycles from the input handshake to out_valid.
- Throughput: one result per 5 cycles with out_ready held high, using the DONE->ACC back-to-back path.
- `in_ready` is a registered function of state plus combinational out_ready in DONE only. There is no path from in_valid to in_ready.
- Backpressure: while out_valid=1 and out_ready=0, product/overflow hold and in_valid is ignored.
- Reset asserted in ACC or DONE: the transaction is discarded immediately and all outputs return to reset values. After release the block is in IDLE.
- in_valid asserted during ACC is neither acknowledged nor lost. The source holds it per valid/ready rules.

## Structure
- Package `ha_array_pkg`: N_ARR, T_W, B_W, P_W, ACC_W=17, IDX_W=2, and the FSM state enum {IDLE, ACC, DONE}.
- Sub-module `ha_row_weight`, combinational: (t, b) -> v = t + (b<<2). It is instantiated once on the muxed idx-selected pair.
- Top module: capture registers, idx counter, FSM, 17-bit accumulator with shift-by-2*idx, output registers.

## Test plan
- All vectors zero, handshake at E0 -> out_valid after E4, product=0, overflow=0.
- Only ha_array_0_t=9'h001 -> product=1. Only ha_array_3_b=7'h01 -> product=256 (2^(2+6)).
- All t=9'h1FF, all b=7'h7F -> S=86615, product=16'h5257 (21079), overflow=1.
- Product held with out_ready=0 for 3 cycles; in_valid high throughout -> product stable, in_ready=0, no capture until the out_ready edge. Then the capture happens on that same edge.
- Back-to-back: out_ready=1 and in_valid continuously high with alternating sets -> a new out_valid every 5 cycles with correct products and no drops or duplicates.
- rst pulsed at cycle 2 of ACC -> out_valid stays 0, in_ready=1 after release. The next transaction yields the correct product.

Source files
------------

// File: rtl/ha_array_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ha_array_pkg: shared widths and FSM encoding for the HA-array reducer     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package ha_array_pkg;

  localparam int N_ARR = 4;
  localparam int T_W   = 9;
  localparam int B_W   = 7;
  localparam int P_W   = 16;
  localparam int ACC_W = 17;
  localparam int IDX_W = 2;
  // t + (b << 2) peaks at 511 + 508 = 1019
  localparam int V_W   = 10;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ARR - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ha_row_weight.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ha_row_weight: value of one HA array, v = t + (b << 2)                    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module ha_row_weight
  import ha_array_pkg::*;
(
  input  logic [T_W-1:0] t,
  input  logic [B_W-1:0] b,
  output logic [V_W-1:0] v
);

  assign v = V_W'(t) + V_W'({b, 2'b00});

endmodule
`default_nettype wire

// File: rtl/ha_array_reducer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ha_array_reducer: sequential final adder summing four HA arrays into the  |
// | 16-bit product, one array per cycle, valid/ready on both sides.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module ha_array_reducer
  import ha_array_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           overflow
);

  logic [T_W-1:0]   w_t_in [N_ARR];
  logic [B_W-1:0]   w_b_in [N_ARR];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [T_W-1:0]   r_t [N_ARR];
  logic [B_W-1:0]   r_b [N_ARR];
  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_acc;
  logic [P_W-1:0]   r_product;
  logic             r_overflow;

  logic [V_W-1:0]   w_v;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_sum;
  logic             w_capture;
  logic             w_acc_en;
  logic             w_last;
  logic             w_in_ready;

  assign w_t_in[0] = ha_array_0_t;
  assign w_t_in[1] = ha_array_1_t;
  assign w_t_in[2] = ha_array_2_t;
  assign w_t_in[3] = ha_array_3_t;
  assign w_b_in[0] = ha_array_0_b;
  assign w_b_in[1] = ha_array_1_b;
  assign w_b_in[2] = ha_array_2_b;
  assign w_b_in[3] = ha_array_3_b;

  // A single weighting unit serves all arrays through the idx mux.
  ha_row_weight u_row_weight (
    .t (r_t[r_idx]),
    .b (r_b[r_idx]),
    .v (w_v)
  );

  assign w_addend = ACC_W'(w_v) << {r_idx, 1'b0};
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    w_acc_en    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        w_acc_en = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Accepting the result frees the block for a back-to-back capture.
        if (out_ready) begin
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = ACC;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_ARR; k++) begin
        r_t[k] <= '0;
        r_b[k] <= '0;
      end
      r_idx      <= '0;
      r_acc      <= '0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (w_capture) begin
      for (int k = 0; k < N_ARR; k++) begin
        r_t[k] <= w_t_in[k];
        r_b[k] <= w_b_in[k];
      end
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_acc_en) begin
      r_acc <= w_sum;
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        r_product  <= w_sum[P_W-1:0];
        r_overflow <= w_sum[ACC_W-1];
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign product   = r_product;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
